// File: rtl/mem_dump_uart_tx.sv
// Dumps a burst of data-RAM words into a local buffer, then streams them byte by byte
// to a UART transmitter with a fixed inter-byte gap and tx_ready back-pressure.
module mem_dump_uart_tx #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                MAX_WORDS = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(32'h10003A20),
    parameter int                BYTE_GAP  = 12432,
    parameter int                LSB_FIRST = 0
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [$clog2(MAX_WORDS+1)-1:0]   word_count,
    input  logic                             rearm,
    input  logic [DATA_W-1:0]                r_data,
    input  logic                             tx_ready,
    output logic                             req_o,
    output logic                             zwe,
    output logic [ADDR_W-1:0]                r_addr,
    output logic                             txen,
    output logic [7:0]                       txpcdata,
    output logic                             busy,
    output logic                             done
);
    localparam int BPW = DATA_W / 8;
    localparam int CW  = $clog2(MAX_WORDS + 1);
    localparam int IW  = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int BW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam int GW  = $clog2(BYTE_GAP + 2);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_SEND, S_GAP, S_FIN} state_t;

    state_t             r_state, w_state_nxt;
    logic [CW-1:0]      r_n, r_k, r_w, w_n_nxt, w_k_nxt, w_w_nxt, w_n_sel;
    logic [BW-1:0]      r_b, w_b_nxt;
    logic [GW-1:0]      r_gap, w_gap_nxt;
    logic               r_locked, w_locked_nxt;
    logic               w_req_nxt, w_txen_nxt, w_busy_nxt, w_done_nxt;
    logic [ADDR_W-1:0]  w_addr_nxt;
    logic [7:0]         w_txd_nxt, w_byte;
    logic [DATA_W-1:0]  r_buf [2**IW];
    logic [DATA_W-1:0]  w_word;
    logic [31:0]        w_sh;
    logic               w_last;

    assign w_n_sel = (word_count > CW'(MAX_WORDS)) ? CW'(MAX_WORDS) : word_count;
    assign w_word  = r_buf[IW'(r_w)];
    assign w_sh    = (LSB_FIRST != 0) ? 32'(r_b) * 32'd8 : 32'(DATA_W - 8) - 32'(r_b) * 32'd8;
    assign w_byte  = 8'(w_word >> w_sh);
    assign w_last  = (r_w == r_n - CW'(1)) && (r_b == BW'(BPW - 1));

    // FETCH cycle k>=1 returns the word addressed in cycle k-1
    always_ff @(posedge clk) begin
        if (r_state == S_FETCH && r_k != '0) begin
            r_buf[IW'(r_k - CW'(1))] <= r_data;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_n_nxt      = r_n;
        w_k_nxt      = r_k;
        w_w_nxt      = r_w;
        w_b_nxt      = r_b;
        w_gap_nxt    = r_gap;
        w_locked_nxt = r_locked;
        w_req_nxt    = 1'b0;
        w_addr_nxt   = '0;
        w_txen_nxt   = 1'b0;
        w_txd_nxt    = txpcdata;
        w_busy_nxt   = busy;
        w_done_nxt   = 1'b0;
        // rearm is ignored while completion is being signalled so the lockout always sticks
        if (rearm && r_state != S_FIN && !done) begin
            w_locked_nxt = 1'b0;
        end
        case (r_state)
            S_IDLE: begin
                if (start && !r_locked) begin
                    w_busy_nxt = 1'b1;
                    w_n_nxt    = w_n_sel;
                    if (w_n_sel == '0) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_state_nxt = S_FETCH;
                        w_k_nxt     = '0;
                        w_req_nxt   = 1'b1;
                        w_addr_nxt  = BASE_ADDR;
                    end
                end
            end
            S_FETCH: begin
                if (r_k == r_n) begin
                    w_state_nxt = S_SEND;
                    w_w_nxt     = '0;
                    w_b_nxt     = '0;
                end else begin
                    w_req_nxt  = 1'b1;
                    w_addr_nxt = r_addr + ADDR_W'(BPW);
                    w_k_nxt    = r_k + CW'(1);
                end
            end
            S_SEND: begin
                if (tx_ready) begin
                    w_txen_nxt  = 1'b1;
                    w_txd_nxt   = w_byte;
                    w_gap_nxt   = '0;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_gap == GW'(BYTE_GAP)) begin
                    if (w_last) begin
                        w_state_nxt = S_FIN;
                    end else begin
                        w_state_nxt = S_SEND;
                        if (r_b == BW'(BPW - 1)) begin
                            w_b_nxt = '0;
                            w_w_nxt = r_w + CW'(1);
                        end else begin
                            w_b_nxt = r_b + BW'(1);
                        end
                    end
                end else begin
                    w_gap_nxt = r_gap + GW'(1);
                end
            end
            S_FIN: begin
                w_done_nxt   = 1'b1;
                w_busy_nxt   = 1'b0;
                w_locked_nxt = 1'b1;
                w_state_nxt  = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_n      <= '0;
            r_k      <= '0;
            r_w      <= '0;
            r_b      <= '0;
            r_gap    <= '0;
            r_locked <= 1'b0;
            req_o    <= 1'b0;
            zwe      <= 1'b0;
            r_addr   <= '0;
            txen     <= 1'b0;
            txpcdata <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_n      <= w_n_nxt;
            r_k      <= w_k_nxt;
            r_w      <= w_w_nxt;
            r_b      <= w_b_nxt;
            r_gap    <= w_gap_nxt;
            r_locked <= w_locked_nxt;
            req_o    <= w_req_nxt;
            zwe      <= w_req_nxt;
            r_addr   <= w_addr_nxt;
            txen     <= w_txen_nxt;
            txpcdata <= w_txd_nxt;
            busy     <= w_busy_nxt;
            done     <= w_done_nxt;
        end
    end
endmodule

// File: tb/tb_mem_dump_uart_tx.sv
// Bench for mem_dump_uart_tx: MSB-first and LSB-first instances fed from a RAM model,
// checked against expected byte streams derived from the RAM contents.
module tb_mem_dump_uart_tx;
    localparam int AW = 32, DW = 32, MW = 8, BG = 3;
    localparam int CW = $clog2(MW + 1);
    localparam logic [31:0] BASE = 32'h10003A20;

    logic clk = 1'b0, rst = 1'b0, start = 1'b0, start_l = 1'b0, rearm = 1'b0, tx_ready = 1'b0;
    logic [CW-1:0] word_count = '0;
    logic [DW-1:0] r_data = '0, r_data_l = '0;
    logic req_o, zwe, txen, busy, done, req_o_l, zwe_l, txen_l, busy_l, done_l;
    logic [AW-1:0] r_addr, r_addr_l;
    logic [7:0] txpcdata, txpcdata_l;

    logic [31:0] ram [64];
    int cyc = 0, vectors = 0, miscompares = 0, t0 = 0;
    logic [7:0] tx_q[$], txl_q[$], exp_q[$];
    int tx_t[$], rd_t[$];
    logic [31:0] rd_q[$];
    int zwe_bad = 0, done_cnt = 0, done_t = 0, donel_cnt = 0;

    mem_dump_uart_tx #(.BYTE_GAP(BG)) dut (
        .clk(clk), .rst(rst), .start(start), .word_count(word_count), .rearm(rearm),
        .r_data(r_data), .tx_ready(tx_ready), .req_o(req_o), .zwe(zwe), .r_addr(r_addr),
        .txen(txen), .txpcdata(txpcdata), .busy(busy), .done(done));

    mem_dump_uart_tx #(.BYTE_GAP(BG), .LSB_FIRST(1)) dut_l (
        .clk(clk), .rst(rst), .start(start_l), .word_count(word_count), .rearm(rearm),
        .r_data(r_data_l), .tx_ready(tx_ready), .req_o(req_o_l), .zwe(zwe_l), .r_addr(r_addr_l),
        .txen(txen_l), .txpcdata(txpcdata_l), .busy(busy_l), .done(done_l));

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        r_data   <= ram[6'((r_addr - BASE) >> 2)];
        r_data_l <= ram[6'((r_addr_l - BASE) >> 2)];
    end

    always @(negedge clk) begin
        if (txen) begin tx_q.push_back(txpcdata); tx_t.push_back(cyc); end
        if (req_o) begin rd_q.push_back(r_addr); rd_t.push_back(cyc); if (zwe !== 1'b1) zwe_bad++; end
        if (done) begin done_cnt++; done_t = cyc; end
        if (txen_l) txl_q.push_back(txpcdata_l);
        if (done_l) donel_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    function automatic void build_exp(input int n, input bit lsb);
        exp_q.delete();
        for (int w = 0; w < n; w++)
            for (int b = 0; b < 4; b++)
                exp_q.push_back(8'(ram[w] >> (lsb ? 8 * b : 24 - 8 * b)));
    endfunction

    task automatic clear_mon();
        tx_q.delete(); tx_t.delete(); rd_q.delete(); rd_t.delete(); txl_q.delete();
        zwe_bad = 0; done_cnt = 0; donel_cnt = 0;
    endtask

    task automatic randomize_ram();
        for (int i = 0; i < 64; i++) ram[i] = $urandom;
    endtask

    task automatic pulse_rearm();
        @(negedge clk); rearm = 1'b1;
        @(negedge clk); rearm = 1'b0;
    endtask

    task automatic start_run(input int wc);
        @(negedge clk); word_count = CW'(wc); start = 1'b1; t0 = cyc;
        @(negedge clk); start = 1'b0;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL busy_after_start: got %b want 1", busy); end
    endtask

    task automatic wait_done(input int bound, input string nm);
        int st = done_cnt;
        int i = 0;
        while (done_cnt == st && i < bound) begin @(posedge clk); i++; end
        vectors++;
        if (done_cnt == st) begin miscompares++; $display("FAIL %s_timeout: no done after %0d cycles, want done", nm, bound); end
    endtask

    task automatic wait_bytes(input int n, input int bound);
        int i = 0;
        while (tx_q.size() < n && i < bound) begin @(posedge clk); i++; end
        vectors++;
        if (tx_q.size() < n) begin miscompares++; $display("FAIL byte_wait: got %0d bytes want %0d", tx_q.size(), n); end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({req_o, zwe, r_addr, txen, txpcdata, busy, done} !== '0) begin
            miscompares++; $display("FAIL reset_outputs: got req=%b zwe=%b addr=%h txen=%b d=%h busy=%b done=%b want all 0",
                                    req_o, zwe, r_addr, txen, txpcdata, busy, done);
        end
        vectors++;
        if ({req_o_l, zwe_l, r_addr_l, txen_l, txpcdata_l, busy_l, done_l} !== '0) begin
            miscompares++; $display("FAIL reset_outputs_lsb: got nonzero outputs want all 0");
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        int bad = 0;
        randomize_ram();
        ram[0] = 32'h11223344; ram[1] = 32'h55667788; ram[2] = 32'h99AABBCC;
        tx_ready = 1'b1;
        clear_mon();
        start_run(2);
        wait_done(200, "basic");
        @(negedge clk);
        build_exp(2, 1'b0);
        for (int k = 0; k < rd_q.size(); k++) if (rd_q[k] !== BASE + 32'(4 * k) || rd_t[k] != t0 + 1 + k) bad++;
        vectors++;
        if (rd_q.size() != 3 || bad != 0) begin miscompares++; $display("FAIL basic_reads: got %0d reads (%0d wrong) want 3", rd_q.size(), bad); end
        vectors++;
        if (zwe_bad != 0) begin miscompares++; $display("FAIL basic_zwe: got %0d cycles with zwe low want 0", zwe_bad); end
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++) if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (tx_q.size() != 8 || bad != 0) begin miscompares++; $display("FAIL basic_bytes: got %0d bytes (%0d wrong) want 8", tx_q.size(), bad); end
        vectors++;
        if (tx_q.size() != 8 || tx_q[0] !== 8'h11 || tx_q[7] !== 8'h88) begin
            miscompares++; $display("FAIL basic_ends: got first/last wrong want 11/88");
        end
        bad = 0;
        for (int i = 1; i < tx_t.size(); i++) if (tx_t[i] - tx_t[i-1] != BG + 2) bad++;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL basic_spacing: got %0d bad gaps want 0 (spacing %0d)", bad, BG + 2); end
        vectors++;
        if (done_cnt != 1 || busy !== 1'b0 || done !== 1'b0) begin
            miscompares++; $display("FAIL basic_done: got done_cnt=%0d busy=%b done=%b want 1/0/0", done_cnt, busy, done);
        end
    endtask

    task automatic test_lsb();
        int bad = 0, i = 0;
        clear_mon();
        @(negedge clk); word_count = CW'(1); start_l = 1'b1;
        @(negedge clk); start_l = 1'b0;
        while (donel_cnt == 0 && i < 200) begin @(posedge clk); i++; end
        build_exp(1, 1'b1);
        for (int j = 0; j < exp_q.size(); j++) if (j >= txl_q.size() || txl_q[j] !== exp_q[j]) bad++;
        vectors++;
        if (txl_q.size() != 4 || bad != 0 || donel_cnt != 1) begin
            miscompares++; $display("FAIL lsb_bytes: got %0d bytes (%0d wrong) done=%0d want 4 bytes 44,33,22,11", txl_q.size(), bad, donel_cnt);
        end
        vectors++;
        if (txl_q.size() != 4 || txl_q[0] !== 8'h44 || txl_q[3] !== 8'h11) begin
            miscompares++; $display("FAIL lsb_ends: got wrong first/last want 44/11");
        end
    endtask

    task automatic test_zero();
        pulse_rearm();
        clear_mon();
        start_run(0);
        wait_done(20, "zero");
        @(negedge clk);
        vectors++;
        if (rd_q.size() != 0 || tx_q.size() != 0 || done_t != t0 + 2) begin
            miscompares++; $display("FAIL zero_run: got reads=%0d bytes=%0d done_at=+%0d want 0/0/+2", rd_q.size(), tx_q.size(), done_t - t0);
        end
    endtask

    task automatic test_clamp();
        int bad = 0;
        pulse_rearm();
        randomize_ram();
        clear_mon();
        start_run(15);
        wait_done(800, "clamp");
        build_exp(MW, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (rd_q.size() != MW + 1 || tx_q.size() != 32 || bad != 0) begin
            miscompares++; $display("FAIL clamp: got req_cycles=%0d bytes=%0d wrong=%0d want 9/32/0", rd_q.size(), tx_q.size(), bad);
        end
    endtask

    task automatic test_stall();
        int bad = 0, s0, s1, tr;
        pulse_rearm();
        randomize_ram();
        clear_mon();
        tx_ready = 1'b1;
        start_run(2);
        wait_bytes(2, 200);
        @(negedge clk); tx_ready = 1'b0;
        #1 s0 = tx_q.size();
        repeat (20) @(negedge clk);
        #1 s1 = tx_q.size();
        tx_ready = 1'b1; tr = cyc;
        wait_done(200, "stall");
        vectors++;
        if (s1 != s0) begin miscompares++; $display("FAIL stall_quiet: got %0d bytes during stall want 0", s1 - s0); end
        vectors++;
        if (tx_t.size() < 3 || tx_t[2] != tr + 1) begin
            miscompares++; $display("FAIL stall_resume: got third byte at %0d want %0d", (tx_t.size() < 3) ? -1 : tx_t[2], tr + 1);
        end
        build_exp(2, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (tx_q.size() != 8 || bad != 0) begin miscompares++; $display("FAIL stall_bytes: got %0d bytes (%0d wrong) want 8", tx_q.size(), bad); end
    endtask

    task automatic test_lockout();
        int bad = 0, i = 0;
        clear_mon();
        @(negedge clk); word_count = CW'(2); start = 1'b1;
        repeat (2) @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rd_q.size() != 0 || done_cnt != 0) begin
            miscompares++; $display("FAIL lock_ignore: got busy=%b reads=%0d want 0/0", busy, rd_q.size());
        end
        pulse_rearm();
        randomize_ram();
        clear_mon();
        start_run(1);
        wait_done(200, "rearm");
        build_exp(1, 1'b0);
        for (int j = 0; j < exp_q.size(); j++) if (j >= tx_q.size() || tx_q[j] !== exp_q[j]) bad++;
        vectors++;
        if (tx_q.size() != 4 || bad != 0) begin miscompares++; $display("FAIL rearm_run: got %0d bytes (%0d wrong) want 4", tx_q.size(), bad); end
        // rearm held high across the done pulse must not clear the lockout
        pulse_rearm();
        clear_mon();
        start_run(1);
        wait_bytes(4, 200);
        @(negedge clk); rearm = 1'b1;
        while (done !== 1'b1 && i < 50) begin @(negedge clk); i++; end
        @(negedge clk); rearm = 1'b0;
        clear_mon();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(negedge clk);
        vectors++;
        if (busy !== 1'b0 || rd_q.size() != 0) begin
            miscompares++; $display("FAIL rearm_with_done: got busy=%b reads=%0d want still locked 0/0", busy, rd_q.size());
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0, sz;
        pulse_rearm();
        randomize_ram();
        clear_mon();
        start_run(2);
        wait_bytes(2, 200);
        #2 rst = 1'b0;
        #1;
        vectors++;
        if ({req_o, zwe, r_addr, txen, txpcdata, busy, done} !== '0) begin
            miscompares++; $display("FAIL async_reset: got busy=%b d=%h addr=%h want all 0", busy, txpcdata, r_addr);
        end
        repeat (3) @(negedge clk);
        sz = tx_q.size();
        rst = 1'b1;
        repeat (6) @(negedge clk);
        vectors++;
        if (tx_q.size() != sz || busy !== 1'b0) begin
            miscompares++; $display("FAIL post_reset_quiet: got %0d extra bytes busy=%b want 0/0", tx_q.size() - sz, busy);
        end
        clear_mon();
        start_run(2);
        wait_done(200, "after_reset");
        build_exp(2, 1'b0);
        for (int i = 0; i < exp_q.size(); i++) if (i >= tx_q.size() || tx_q[i] !== exp_q[i]) bad++;
        vectors++;
        if (rd_q.size() != 3 || tx_q.size() != 8 || bad != 0) begin
            miscompares++; $display("FAIL reset_rerun: got reads=%0d bytes=%0d wrong=%0d want 3/8/0", rd_q.size(), tx_q.size(), bad);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) ram[i] = '0;
        test_reset();
        test_basic();
        test_lsb();
        test_zero();
        test_clamp();
        test_stall();
        test_lockout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
